// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//
// Hazard controller for the five-stage MIPS core. Compares the D- and E-stage
// source registers against the destinations carried in the E, M and W pipeline
// registers. From that comparison it produces:
//   - the stall/flush controls that freeze F and D and bubble E,
//   - the D- and E-stage forwarding selects,
//   - the busy counter that serialises the shared HI/LO multiply/divide unit,
//   - a saturating count of stalled cycles.
//
// Parameters
//   MULT_CYCLES   busy cycles after a mult/multu issues
//   DIV_CYCLES    busy cycles after a div/divu issues
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous reset, active low
//   A_rsD, A_rtD           D-stage source register numbers
//   TuseRsD, TuseRtD       cycles until D needs rs/rt (3 = never used)
//   MdUseD                 D-stage instruction uses the HI/LO unit
//   A_rsE, A_rtE           E-stage source register numbers
//   AwriteE/M/W            destination register per stage
//   RegWriteE/M/W          stage will write the register file
//   TnewE, TnewM           cycles until the stage's result is available
//   MdStartE               E-stage instruction starts a mult/div
//   MdIsDivE               qualifies MdStartE: 1 = divide, 0 = multiply
//   StallF, StallD         hold PC / hold F/D register
//   FlushE                 load a bubble into the D/E register
//   MdBusy                 HI/LO unit occupied (registered state)
//   FwdRsD, FwdRtD         D forward select: 0 = regfile, 1 = W, 2 = M
//   FwdRsE, FwdRtE         E forward select: 0 = D/E value, 1 = W, 2 = M
//   StallCount             stalled cycles since reset, saturating
// -----------------------------------------------------------------------------
module hazard_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [4:0]  A_rsD,
    input  logic [4:0]  A_rtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic        MdUseD,

    input  logic [4:0]  A_rsE,
    input  logic [4:0]  A_rtE,

    input  logic [4:0]  AwriteE,
    input  logic [4:0]  AwriteM,
    input  logic [4:0]  AwriteW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  TnewE,
    input  logic [1:0]  TnewM,

    input  logic        MdStartE,
    input  logic        MdIsDivE,

    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        MdBusy,
    output logic [1:0]  FwdRsD,
    output logic [1:0]  FwdRtD,
    output logic [1:0]  FwdRsE,
    output logic [1:0]  FwdRtE,
    output logic [31:0] StallCount
);

    // Counter must hold the longer of the two latencies, and is never
    // narrower than 4 bits.
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;

    // ------------------------------------------------------------------
    // Register-number comparison helpers. $0 is hardwired to zero and so
    // can never create a dependency.
    // ------------------------------------------------------------------
    function automatic logic src_match(
        input logic       reg_write,
        input logic [4:0] awrite,
        input logic [4:0] src
    );
        return reg_write && (awrite == src) && (src != 5'd0);
    endfunction

    // M result wins over W because it is the younger write to the register.
    // M only forwards once its value actually exists (Tnew == 0).
    function automatic logic [1:0] fwd_sel(
        input logic match_m,
        input logic tnew_m_zero,
        input logic match_w
    );
        if (match_m && tnew_m_zero) begin
            return FWD_M;
        end else if (match_w) begin
            return FWD_W;
        end else begin
            return FWD_NONE;
        end
    endfunction

    // ------------------------------------------------------------------
    // Source matches
    // ------------------------------------------------------------------
    logic rs_d_match_e, rs_d_match_m, rs_d_match_w;
    logic rt_d_match_e, rt_d_match_m, rt_d_match_w;
    logic rs_e_match_m, rs_e_match_w;
    logic rt_e_match_m, rt_e_match_w;

    always_comb begin
        rs_d_match_e = src_match(RegWriteE, AwriteE, A_rsD);
        rs_d_match_m = src_match(RegWriteM, AwriteM, A_rsD);
        rs_d_match_w = src_match(RegWriteW, AwriteW, A_rsD);
        rt_d_match_e = src_match(RegWriteE, AwriteE, A_rtD);
        rt_d_match_m = src_match(RegWriteM, AwriteM, A_rtD);
        rt_d_match_w = src_match(RegWriteW, AwriteW, A_rtD);
        rs_e_match_m = src_match(RegWriteM, AwriteM, A_rsE);
        rs_e_match_w = src_match(RegWriteW, AwriteW, A_rsE);
        rt_e_match_m = src_match(RegWriteM, AwriteM, A_rtE);
        rt_e_match_w = src_match(RegWriteW, AwriteW, A_rtE);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] md_cnt_q,    md_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic md_busy;
    assign md_busy = (md_cnt_q != '0);

    // ------------------------------------------------------------------
    // Stall decision. A consumer must wait while the producer's result
    // arrives later (Tnew) than the consumer needs it (Tuse).
    // ------------------------------------------------------------------
    logic stall_rs, stall_rt, stall_md, stall_raw;

    always_comb begin
        stall_rs  = (rs_d_match_e && (TuseRsD < TnewE)) ||
                    (rs_d_match_m && (TuseRsD < TnewM));
        stall_rt  = (rt_d_match_e && (TuseRtD < TnewE)) ||
                    (rt_d_match_m && (TuseRtD < TnewM));
        // MdStartE covers the issue cycle itself, before the counter has
        // been loaded, so the stall starts without a one-cycle hole.
        stall_md  = MdUseD && (md_busy || MdStartE);
        stall_raw = stall_rs || stall_rt || stall_md;
    end

    // While reset is low the pipeline must not see stalls or forwards.
    logic stall;
    assign stall = reset && stall_raw;

    always_comb begin
        StallF = stall;
        StallD = stall;
        FlushE = stall;

        FwdRsD = FWD_NONE;
        FwdRtD = FWD_NONE;
        FwdRsE = FWD_NONE;
        FwdRtE = FWD_NONE;
        if (reset) begin
            FwdRsD = fwd_sel(rs_d_match_m, (TnewM == 2'd0), rs_d_match_w);
            FwdRtD = fwd_sel(rt_d_match_m, (TnewM == 2'd0), rt_d_match_w);
            FwdRsE = fwd_sel(rs_e_match_m, (TnewM == 2'd0), rs_e_match_w);
            FwdRtE = fwd_sel(rt_e_match_m, (TnewM == 2'd0), rt_e_match_w);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        md_cnt_d = md_cnt_q;
        // A new start always reloads; it never adds to the remaining time.
        if (MdStartE) begin
            md_cnt_d = MdIsDivE ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MdBusy     = md_busy;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A_rsD, A_rtD, A_rsE, A_rtE;
    logic [1:0]  TuseRsD, TuseRtD, TnewE, TnewM;
    logic        MdUseD, MdStartE, MdIsDivE;
    logic [4:0]  AwriteE, AwriteM, AwriteW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        StallF, StallD, FlushE, MdBusy;
    logic [1:0]  FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic [31:0] StallCount;

    always #5 clk = ~clk;

    hazard_scheduler #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A_rsD      (A_rsD),
        .A_rtD      (A_rtD),
        .TuseRsD    (TuseRsD),
        .TuseRtD    (TuseRtD),
        .MdUseD     (MdUseD),
        .A_rsE      (A_rsE),
        .A_rtE      (A_rtE),
        .AwriteE    (AwriteE),
        .AwriteM    (AwriteM),
        .AwriteW    (AwriteW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .TnewE      (TnewE),
        .TnewM      (TnewM),
        .MdStartE   (MdStartE),
        .MdIsDivE   (MdIsDivE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .MdBusy     (MdBusy),
        .FwdRsD     (FwdRsD),
        .FwdRtD     (FwdRtD),
        .FwdRsE     (FwdRsE),
        .FwdRtE     (FwdRtE),
        .StallCount (StallCount)
    );

    typedef enum int {S_STALL, S_BUSY, S_FRSD, S_FRTD, S_FRSE, S_FRTE, S_CNT} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_sc = 0;   // stalled cycles expected so far since last reset

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_STALL: return {29'd0, StallF, StallD, FlushE};
            S_BUSY:  return {31'd0, MdBusy};
            S_FRSD:  return {30'd0, FwdRsD};
            S_FRTD:  return {30'd0, FwdRtD};
            S_FRSE:  return {30'd0, FwdRsE};
            S_FRTE:  return {30'd0, FwdRtE};
            default: return StallCount;
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.sig = s;
        item.exp = e;
        sb.push_back(item);
    endtask

    // Push the StallCount expectation for a cycle before its stall expectation.
    task automatic exp_cnt(input string tag);
        push(tag, S_CNT, exp_sc);
    endtask

    task automatic exp_stall(input string tag, input bit s);
        push(tag, S_STALL, s ? 32'd7 : 32'd0);
        if (s) exp_sc++;
    endtask

    task automatic sample();
        exp_t item;
        @(negedge clk);
        while (sb.size() > 0) begin
            item = sb.pop_front();
            check_val(item.tag, observe(item.sig), item.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        A_rsD = 0; A_rtD = 0; A_rsE = 0; A_rtE = 0;
        TuseRsD = 2'd3; TuseRtD = 2'd3; MdUseD = 0;
        AwriteE = 0; AwriteM = 0; AwriteW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        TnewE = 0; TnewM = 0;
        MdStartE = 0; MdIsDivE = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held while a divide starts and hazards are present.
        defaults();
        reset = 1'b0;
        MdStartE = 1; MdIsDivE = 1; MdUseD = 1;
        AwriteE = 8; RegWriteE = 1; TnewE = 2; A_rsD = 8; TuseRsD = 0;
        AwriteM = 5; RegWriteM = 1; TnewM = 0; A_rtE = 5; A_rtD = 5;
        for (int i = 0; i < 2; i++) begin
            push("rst_busy", S_BUSY, 0);
            exp_stall("rst_stall", 0);
            push("rst_frsd", S_FRSD, 0);
            push("rst_frtd", S_FRTD, 0);
            push("rst_frte", S_FRTE, 0);
            sample();
        end
        defaults();
        reset = 1'b1;
        cyc();
        push("post_rst_busy", S_BUSY, 0);
        exp_cnt("post_rst_cnt");
        exp_stall("post_rst_stall", 0);
        sample();

        // Load-use, consumer Tuse=0: two stall cycles, release with M forwarding.
        cyc();
        AwriteE = 8; RegWriteE = 1; TnewE = 2; A_rsD = 8; TuseRsD = 0;
        exp_cnt("lu_cnt0");
        exp_stall("lu_stall0", 1);
        sample();
        cyc();
        AwriteE = 0; RegWriteE = 0; TnewE = 0;
        AwriteM = 8; RegWriteM = 1; TnewM = 1;
        exp_stall("lu_stall1", 1);
        sample();
        cyc();
        TnewM = 0;
        exp_cnt("lu_cnt2");
        exp_stall("lu_release", 0);
        push("lu_frsd", S_FRSD, 2);
        sample();

        // Load-use, consumer Tuse=1: one stall cycle.
        cyc();
        defaults();
        AwriteE = 12; RegWriteE = 1; TnewE = 2; A_rtD = 12; TuseRtD = 1;
        exp_stall("lu1_stall", 1);
        sample();
        cyc();
        AwriteE = 0; RegWriteE = 0; TnewE = 0;
        AwriteM = 12; RegWriteM = 1; TnewM = 1;
        exp_stall("lu1_release", 0);
        push("lu1_frtd_notready", S_FRTD, 0);
        sample();

        // $0 never matches.
        cyc();
        defaults();
        AwriteE = 0; RegWriteE = 1; TnewE = 2; A_rsD = 0; TuseRsD = 0;
        AwriteM = 0; RegWriteM = 1; TnewM = 0;
        AwriteW = 0; RegWriteW = 1;
        exp_stall("zero_stall", 0);
        push("zero_frsd", S_FRSD, 0);
        sample();

        // Forward priority M over W, then W alone.
        cyc();
        defaults();
        AwriteM = 9; AwriteW = 9; RegWriteM = 1; RegWriteW = 1; TnewM = 0;
        A_rtE = 9; A_rtD = 9; A_rsE = 9;
        push("prio_frte", S_FRTE, 2);
        push("prio_frse", S_FRSE, 2);
        push("prio_frtd", S_FRTD, 2);
        exp_stall("prio_stall", 0);
        sample();
        cyc();
        RegWriteM = 0;
        push("wonly_frte", S_FRTE, 1);
        push("wonly_frtd", S_FRTD, 1);
        exp_stall("wonly_stall", 0);
        sample();
        cyc();
        RegWriteM = 1; TnewM = 1; TuseRtD = 1;
        push("mnotready_frte", S_FRTE, 1);
        exp_stall("tuse_eq_tnew", 0);
        sample();
        cyc();
        TuseRtD = 0;
        exp_stall("tuse_lt_tnewm", 1);
        sample();

        // Divide with mfhi in D from the issue cycle.
        cyc();
        defaults();
        MdStartE = 1; MdIsDivE = 1; MdUseD = 1;
        exp_cnt("div_cnt_start");
        push("div_busy_c0", S_BUSY, 0);
        exp_stall("div_stall_c0", 1);
        sample();
        for (int c = 1; c <= DIV_CYCLES; c++) begin
            cyc();
            MdStartE = 0; MdIsDivE = 0;
            push($sformatf("div_busy_c%0d", c), S_BUSY, 1);
            exp_stall($sformatf("div_stall_c%0d", c), 1);
            sample();
        end
        cyc();
        push("div_busy_end", S_BUSY, 0);
        exp_cnt("div_cnt_end");
        exp_stall("div_release", 0);
        sample();

        // Multiply at cycle 0, divide reload at cycle 3, MD consumer from cycle 2.
        cyc();
        defaults();
        MdStartE = 1; MdIsDivE = 0;
        push("rl_busy_c0", S_BUSY, 0);
        exp_stall("rl_stall_c0", 0);
        sample();
        for (int c = 1; c <= 14; c++) begin
            cyc();
            MdStartE = (c == 3);
            MdIsDivE = (c == 3);
            MdUseD   = (c >= 2);
            push($sformatf("rl_busy_c%0d", c), S_BUSY, (c <= 13) ? 32'd1 : 32'd0);
            if (c == 14) exp_cnt("rl_cnt_end");
            exp_stall($sformatf("rl_stall_c%0d", c), (c >= 2) && (c <= 13));
            sample();
        end

        // Reset asserted mid-multiply.
        cyc();
        defaults();
        MdStartE = 1;
        push("mr_busy_c0", S_BUSY, 0);
        exp_stall("mr_stall_c0", 0);
        sample();
        cyc();
        MdStartE = 0; MdUseD = 1; reset = 1'b0;
        push("mr_busy_c1", S_BUSY, 1);
        exp_stall("mr_stall_forced", 0);
        sample();
        cyc();
        reset = 1'b1; MdUseD = 0;
        exp_sc = 0;
        push("mr_busy_cleared", S_BUSY, 0);
        exp_cnt("mr_cnt_cleared");
        sample();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
